// File: rtl/tracker_pkg.sv
// ============================================================================
// tracker_pkg : shared constants for the pose tracker (moves, states, screen)
// Rev 1.0
// ============================================================================
`default_nettype none

package tracker_pkg;

    localparam int unsigned c_SCREEN_W = 640;
    localparam int unsigned c_SCREEN_H = 480;
    localparam int          c_EMA_W    = 11;

    localparam logic [2:0] c_MOVE_NONE  = 3'd0;
    localparam logic [2:0] c_MOVE_UP    = 3'd1;
    localparam logic [2:0] c_MOVE_DOWN  = 3'd2;
    localparam logic [2:0] c_MOVE_LEFT  = 3'd3;
    localparam logic [2:0] c_MOVE_RIGHT = 3'd4;

    localparam logic [1:0] c_ST_LOST    = 2'd0;
    localparam logic [1:0] c_ST_TRACK   = 2'd1;
    localparam logic [1:0] c_ST_CONFIRM = 2'd2;

    typedef logic signed [c_EMA_W-1:0] coord_t;

    function automatic logic [c_EMA_W-1:0] absCoord(input coord_t v);
        return v[c_EMA_W-1] ? c_EMA_W'(-v) : c_EMA_W'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pose_tracker_if.sv
// ============================================================================
// pose_tracker_if : detector-side inputs and tracker outputs of pose_tracker
// Rev 1.0
// ============================================================================
`default_nettype none

interface pose_tracker_if;
    logic        iVgaVRequest;
    logic [15:0] iRedPixelHIndex;
    logic [15:0] iRedPixelVIndex;
    logic        iEnable;
    logic [9:0]  oPosX;
    logic [8:0]  oPosY;
    logic        oPosValid;
    logic [2:0]  oMove;
    logic        oMoveValid;
    logic [15:0] oFrameCount;

    modport master (
        output iVgaVRequest, iRedPixelHIndex, iRedPixelVIndex, iEnable,
        input  oPosX, oPosY, oPosValid, oMove, oMoveValid, oFrameCount
    );

    modport slave (
        input  iVgaVRequest, iRedPixelHIndex, iRedPixelVIndex, iEnable,
        output oPosX, oPosY, oPosValid, oMove, oMoveValid, oFrameCount
    );
endinterface

`default_nettype wire

// File: rtl/axis_ema.sv
// ============================================================================
// axis_ema : one-axis exponential moving average with direct-load option
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_ema #(
    parameter int WIDTH = 11,
    parameter int SHIFT = 2
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    load,
    input  wire logic                    update,
    input  wire logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0]      avg,
    output logic signed [WIDTH-1:0]      avgNext
);

    logic signed [WIDTH-1:0] r_avg;
    logic signed [WIDTH-1:0] w_diff;
    logic signed [WIDTH-1:0] w_step;

    // The step always lies between avg and sample, so the result stays on screen.
    assign w_diff = sample - r_avg;
    assign w_step = w_diff >>> SHIFT;

    always_comb begin
        avgNext = r_avg;
        if (load)
            avgNext = sample;
        else if (update)
            avgNext = r_avg + w_step;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_avg <= '0;
        else
            r_avg <= avgNext;
    end

    assign avg = r_avg;

endmodule

`default_nettype wire

// File: rtl/pose_tracker.sv
// ============================================================================
// pose_tracker : per-frame filtered object position and debounced move codes
// Rev 1.0
// ============================================================================
`default_nettype none

module pose_tracker
    import tracker_pkg::*;
#(
    parameter int SHIFT       = 2,
    parameter int THRESH      = 16,
    parameter int HOLD_FRAMES = 3
) (
    input  wire logic     iVgaClk,
    input  wire logic     reset,
    pose_tracker_if.slave bus
);

    localparam int                 c_CNT_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD   = c_CNT_W'(HOLD_FRAMES);
    localparam logic [c_EMA_W-1:0] c_THRESH = c_EMA_W'(THRESH);

    logic               r_vReq;
    logic               w_frameEnd;
    logic               w_accept;
    logic               w_sampleValid;
    logic               w_load;
    logic               w_update;
    coord_t             w_sampleX;
    coord_t             w_sampleY;
    coord_t             w_avgX;
    coord_t             w_avgY;
    coord_t             w_nextX;
    coord_t             w_nextY;
    coord_t             r_anchorX;
    coord_t             r_anchorY;
    coord_t             w_dx;
    coord_t             w_dy;
    logic [c_EMA_W-1:0] w_absX;
    logic [c_EMA_W-1:0] w_absY;
    logic [2:0]         w_dir;
    logic [2:0]         r_pendDir;
    logic [2:0]         r_move;
    logic               r_moveValid;
    logic               r_posValid;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cntInc;
    logic [15:0]        r_frameCount;
    logic               w_unusedBits;

    assign w_frameEnd    = r_vReq & ~bus.iVgaVRequest;
    assign w_accept      = w_frameEnd & bus.iEnable;
    assign w_sampleValid = (bus.iRedPixelVIndex < 16'(c_SCREEN_W)) &&
                           (bus.iRedPixelHIndex < 16'(c_SCREEN_H));
    assign w_sampleX     = coord_t'({1'b0, bus.iRedPixelVIndex[9:0]});
    assign w_sampleY     = coord_t'({2'b0, bus.iRedPixelHIndex[8:0]});
    assign w_load        = w_accept & w_sampleValid & (r_state == c_ST_LOST);
    assign w_update      = w_accept & w_sampleValid & (r_state != c_ST_LOST);

    axis_ema #(.WIDTH(c_EMA_W), .SHIFT(SHIFT)) u_emaX (
        .clk     (iVgaClk),
        .rst     (reset),
        .load    (w_load),
        .update  (w_update),
        .sample  (w_sampleX),
        .avg     (w_avgX),
        .avgNext (w_nextX)
    );

    axis_ema #(.WIDTH(c_EMA_W), .SHIFT(SHIFT)) u_emaY (
        .clk     (iVgaClk),
        .rst     (reset),
        .load    (w_load),
        .update  (w_update),
        .sample  (w_sampleY),
        .avg     (w_avgY),
        .avgNext (w_nextY)
    );

    // Displacement uses the average as it will be after this frame.
    assign w_dx     = w_nextX - r_anchorX;
    assign w_dy     = w_nextY - r_anchorY;
    assign w_absX   = absCoord(w_dx);
    assign w_absY   = absCoord(w_dy);
    assign w_cntInc = r_cnt + 1'b1;

    // Horizontal takes priority on equal magnitudes.
    always_comb begin
        w_dir = c_MOVE_NONE;
        if ((w_absX > c_THRESH) && (w_absX >= w_absY))
            w_dir = w_dx[c_EMA_W-1] ? c_MOVE_LEFT : c_MOVE_RIGHT;
        else if (w_absY > c_THRESH)
            w_dir = w_dy[c_EMA_W-1] ? c_MOVE_UP : c_MOVE_DOWN;
    end

    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            r_vReq       <= 1'b0;
            r_state      <= c_ST_LOST;
            r_cnt        <= '0;
            r_pendDir    <= c_MOVE_NONE;
            r_anchorX    <= '0;
            r_anchorY    <= '0;
            r_posValid   <= 1'b0;
            r_move       <= c_MOVE_NONE;
            r_moveValid  <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_vReq      <= bus.iVgaVRequest;
            r_moveValid <= 1'b0;
            if (w_accept) begin
                r_frameCount <= r_frameCount + 16'd1;
                if (!w_sampleValid) begin
                    r_state    <= c_ST_LOST;
                    r_posValid <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    case (r_state)
                        c_ST_LOST: begin
                            r_anchorX  <= w_sampleX;
                            r_anchorY  <= w_sampleY;
                            r_posValid <= 1'b1;
                            r_state    <= c_ST_TRACK;
                        end
                        c_ST_TRACK: begin
                            if (w_dir != c_MOVE_NONE) begin
                                r_pendDir <= w_dir;
                                r_cnt     <= c_CNT_W'(1);
                                r_state   <= c_ST_CONFIRM;
                            end
                        end
                        c_ST_CONFIRM: begin
                            if (w_dir == r_pendDir) begin
                                if (w_cntInc == c_HOLD) begin
                                    r_move      <= w_dir;
                                    r_moveValid <= 1'b1;
                                    r_anchorX   <= w_nextX;
                                    r_anchorY   <= w_nextY;
                                    r_cnt       <= '0;
                                    r_state     <= c_ST_TRACK;
                                end else begin
                                    r_cnt <= w_cntInc;
                                end
                            end else begin
                                r_cnt   <= '0;
                                r_state <= c_ST_TRACK;
                            end
                        end
                        default: begin
                            r_cnt   <= '0;
                            r_state <= c_ST_LOST;
                        end
                    endcase
                end
            end
        end
    end

    // Averages never exceed 639/479, so the top bits are always zero.
    assign w_unusedBits    = ^{w_avgX[c_EMA_W-1], w_avgY[c_EMA_W-1:9]};

    assign bus.oPosX       = w_avgX[9:0];
    assign bus.oPosY       = w_avgY[8:0];
    assign bus.oPosValid   = r_posValid;
    assign bus.oMove       = r_move;
    assign bus.oMoveValid  = r_moveValid;
    assign bus.oFrameCount = r_frameCount;

endmodule

`default_nettype wire

// File: tb/tb_pose_tracker.sv
// ============================================================================
// tb_pose_tracker : directed vector table plus corner sequences for pose_tracker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pose_tracker;
    import tracker_pkg::*;

    typedef struct {
        logic [15:0] col;
        logic [15:0] row;
        logic        en;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        v;
        logic        mv;
        logic [2:0]  m;
        logic [15:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   totalCount;
    int   passCount;
    int   pulseCount;
    int   pulseBase;
    vec_t vecs[14];

    pose_tracker_if bus ();

    pose_tracker #(.SHIFT(2), .THRESH(16), .HOLD_FRAMES(3)) dut (
        .iVgaClk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.oMoveValid === 1'b1)
            pulseCount <= pulseCount + 1;
    end

    task automatic checkOut(input string name, input logic [9:0] x, input logic [8:0] y,
                            input logic v, input logic mv, input logic [2:0] m,
                            input logic [15:0] cnt);
        totalCount++;
        if (bus.oPosX === x && bus.oPosY === y && bus.oPosValid === v &&
            bus.oMoveValid === mv && bus.oMove === m && bus.oFrameCount === cnt) begin
            passCount++;
        end else begin
            $display("FAIL %s: got x=%0d y=%0d v=%0b mv=%0b m=%0d cnt=%0d, expected x=%0d y=%0d v=%0b mv=%0b m=%0d cnt=%0d",
                     name, bus.oPosX, bus.oPosY, bus.oPosValid, bus.oMoveValid, bus.oMove,
                     bus.oFrameCount, x, y, v, mv, m, cnt);
        end
    endtask

    task automatic checkVal(input string name, input int actual, input int expected);
        totalCount++;
        if (actual == expected)
            passCount++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        bus.iVgaVRequest = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame: request high for a cycle, then its falling edge; sample after the update edge.
    task automatic applyFrame(input logic [15:0] col, input logic [15:0] row, input logic en);
        @(negedge clk);
        bus.iVgaVRequest    = 1'b1;
        bus.iRedPixelVIndex = col;
        bus.iRedPixelHIndex = row;
        bus.iEnable         = en;
        @(negedge clk);
        bus.iVgaVRequest = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        totalCount = 0;
        passCount  = 0;
        pulseCount = 0;
        reset               = 1'b1;
        bus.iVgaVRequest    = 1'b0;
        bus.iRedPixelVIndex = '0;
        bus.iRedPixelHIndex = '0;
        bus.iEnable         = 1'b1;

        //               col     row    en    x      y     v     mv    m     cnt
        vecs[0]  = '{16'd100,  16'd200, 1'b1, 10'd100, 9'd200, 1'b1, 1'b0, 3'd0, 16'd1};
        vecs[1]  = '{16'd300,  16'd200, 1'b1, 10'd150, 9'd200, 1'b1, 1'b0, 3'd0, 16'd2};
        vecs[2]  = '{16'd300,  16'd200, 1'b1, 10'd187, 9'd200, 1'b1, 1'b0, 3'd0, 16'd3};
        vecs[3]  = '{16'd300,  16'd200, 1'b1, 10'd215, 9'd200, 1'b1, 1'b1, 3'd4, 16'd4};
        vecs[4]  = '{16'd0,    16'd0,   1'b0, 10'd215, 9'd200, 1'b1, 1'b0, 3'd4, 16'd4};
        vecs[5]  = '{16'd1023, 16'd200, 1'b1, 10'd215, 9'd200, 1'b0, 1'b0, 3'd4, 16'd5};
        vecs[6]  = '{16'd50,   16'd100, 1'b1, 10'd50,  9'd100, 1'b1, 1'b0, 3'd4, 16'd6};
        vecs[7]  = '{16'd50,   16'd20,  1'b1, 10'd50,  9'd80,  1'b1, 1'b0, 3'd4, 16'd7};
        vecs[8]  = '{16'd50,   16'd20,  1'b1, 10'd50,  9'd65,  1'b1, 1'b0, 3'd4, 16'd8};
        vecs[9]  = '{16'd50,   16'd20,  1'b1, 10'd50,  9'd53,  1'b1, 1'b1, 3'd1, 16'd9};
        vecs[10] = '{16'd150,  16'd153, 1'b1, 10'd75,  9'd78,  1'b1, 1'b0, 3'd1, 16'd10};
        vecs[11] = '{16'd639,  16'd479, 1'b1, 10'd216, 9'd178, 1'b1, 1'b0, 3'd1, 16'd11};
        vecs[12] = '{16'd640,  16'd0,   1'b1, 10'd216, 9'd178, 1'b0, 1'b0, 3'd1, 16'd12};
        vecs[13] = '{16'd0,    16'd479, 1'b1, 10'd0,   9'd479, 1'b1, 1'b0, 3'd1, 16'd13};

        resetDut();
        #1;
        checkOut("reset_outputs", 10'd0, 9'd0, 1'b0, 1'b0, 3'd0, 16'd0);
        checkVal("reset_state", int'(dut.r_state), int'(c_ST_LOST));

        for (int i = 0; i < 14; i++) begin
            applyFrame(vecs[i].col, vecs[i].row, vecs[i].en);
            checkOut($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].v,
                     vecs[i].mv, vecs[i].m, vecs[i].cnt);
        end
        repeat (2) @(negedge clk);
        checkVal("table_pulse_count", pulseCount, 2);

        // Confirm interrupted by a below-threshold frame, then reset mid-confirm.
        resetDut();
        pulseBase = pulseCount;
        applyFrame(16'd100, 16'd200, 1'b1);
        checkOut("irq_lock", 10'd100, 9'd200, 1'b1, 1'b0, 3'd0, 16'd1);
        applyFrame(16'd180, 16'd200, 1'b1);
        checkOut("irq_r1", 10'd120, 9'd200, 1'b1, 1'b0, 3'd0, 16'd2);
        applyFrame(16'd180, 16'd200, 1'b1);
        checkOut("irq_r2", 10'd135, 9'd200, 1'b1, 1'b0, 3'd0, 16'd3);
        applyFrame(16'd0, 16'd200, 1'b1);
        checkOut("irq_small", 10'd101, 9'd200, 1'b1, 1'b0, 3'd0, 16'd4);
        checkVal("irq_state_track", int'(dut.r_state), int'(c_ST_TRACK));
        checkVal("irq_cnt_cleared", int'(dut.r_cnt), 0);
        applyFrame(16'd200, 16'd200, 1'b1);
        checkOut("rst_r1", 10'd125, 9'd200, 1'b1, 1'b0, 3'd0, 16'd5);
        applyFrame(16'd200, 16'd200, 1'b1);
        checkOut("rst_r2", 10'd143, 9'd200, 1'b1, 1'b0, 3'd0, 16'd6);
        checkVal("rst_state_confirm", int'(dut.r_state), int'(c_ST_CONFIRM));

        // Frame end lands on the same edge as reset.
        @(negedge clk);
        bus.iVgaVRequest    = 1'b1;
        bus.iRedPixelVIndex = 16'd200;
        bus.iRedPixelHIndex = 16'd200;
        @(negedge clk);
        bus.iVgaVRequest = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOut("rst_fe_outputs", 10'd0, 9'd0, 1'b0, 1'b0, 3'd0, 16'd0);
        checkVal("rst_fe_state", int'(dut.r_state), int'(c_ST_LOST));
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("no_pulse_after_irq_rst", pulseCount - pulseBase, 0);
        applyFrame(16'd200, 16'd200, 1'b1);
        checkOut("relock", 10'd200, 9'd200, 1'b1, 1'b0, 3'd0, 16'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pose_tracker.md
POSE_TRACKER -- requirements
Module: pose_tracker

Interface
REQ-001 SHALL have parameter SHIFT, default 2: EMA smoothing shift, where new average = avg + (sample - avg) >>> SHIFT.
REQ-002 SHALL have parameter THRESH, default 16: minimum pixel displacement from the anchor that counts as motion.
REQ-003 SHALL have parameter HOLD_FRAMES, default 3: number of consecutive frames in the same direction needed to emit a move.
REQ-004 SHALL have port iVgaClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port iVgaVRequest, input, 1 bit: high during active lines; its falling edge marks end of frame.
REQ-007 SHALL have port iRedPixelHIndex, input, 16 bits: detected object row (Y) from the detector.
REQ-008 SHALL have port iRedPixelVIndex, input, 16 bits: detected object column (X) from the detector.
REQ-009 SHALL have port iEnable, input, 1 bit: when low, end-of-frame events are ignored.
REQ-010 SHALL have port oPosX, output, 10 bits: filtered column.
REQ-011 SHALL have port oPosY, output, 9 bits: filtered row.
REQ-012 SHALL have port oPosValid, output, 1 bit: high while the object is locked.
REQ-013 SHALL have port oMove, output, 3 bits: move code (0 none, 1 up, 2 down, 3 left, 4 right).
REQ-014 SHALL have port oMoveValid, output, 1 bit: one-cycle pulse marking oMove as valid.
REQ-015 SHALL have port oFrameCount, output, 16 bits: count of accepted frames; wraps from 65535 to 0.

Function
REQ-016 SHALL register iVgaVRequest and detect a frame end (FE) on any cycle where the registered value is 1 and the current value is 0.
REQ-017 SHALL ignore an FE when iEnable=0: no state change, no output change, no count increment.
REQ-018 SHALL treat an accepted FE sample as valid only if column < 640 and row < 480; the sample is then truncated to 10/9 bits.
REQ-019 SHALL update oPosX, oPosY, oPosValid, oMove, oMoveValid and oFrameCount on the clock edge following the FE cycle (1-cycle latency).
REQ-020 SHALL compute the EMA per axis in signed 11-bit arithmetic with an arithmetic right shift, and the result SHALL never leave 0..639 / 0..479.
REQ-021 SHALL implement the states LOST, TRACK and CONFIRM.
REQ-022 In LOST, a valid sample SHALL load the average and the anchor directly (no filtering), set oPosValid=1, and go to TRACK.
REQ-023 In any state, an invalid sample SHALL go to LOST, clear oPosValid, clear the confirm counter, and hold oPosX/oPosY unchanged.
REQ-024 In TRACK and CONFIRM, the step SHALL compute dx = avg_x - anchor_x and dy = avg_y - anchor_y using the newly updated average.
REQ-025 Direction SHALL be the dominant axis where |d| > THRESH: dx>0 is right, dx<0 is left, dy>0 is down, dy<0 is up; when |dx|==|dy|, horizontal wins; otherwise none.
REQ-026 In TRACK, direction none SHALL stay in TRACK; a direction D SHALL latch D, set counter=1, and go to CONFIRM.
REQ-027 In CONFIRM, the same D SHALL increment the counter; when the counter reaches HOLD_FRAMES, the block SHALL emit oMove=D with oMoveValid=1, set anchor := avg, and go to TRACK.
REQ-028 In CONFIRM, a different direction or none SHALL clear the counter and go to TRACK without emitting.
REQ-029 oMoveValid SHALL be high for exactly one cycle, and oMove SHALL hold its last code between pulses.
REQ-030 oFrameCount SHALL increment on every accepted FE, whether the sample is valid or invalid.

Reset
REQ-031 On reset, the block SHALL enter LOST and set oPosX=0, oPosY=0, oPosValid=0, oMove=0, oMoveValid=0, oFrameCount=0, counter=0, and the registered iVgaVRequest=0.
REQ-032 Reset asserted mid-CONFIRM SHALL discard the pending move, and no pulse SHALL follow.
REQ-033 An FE coincident with reset SHALL be ignored.

Structure
REQ-034 Package tracker_pkg SHALL hold the move-code constants, the state encoding, and the screen-size constants 640 and 480.
REQ-035 Sub-module axis_ema (parameters WIDTH, SHIFT; inputs load, update, sample; output avg) SHALL be instantiated once per axis.

Verification
REQ-036 Reset: assert reset for 2 cycles -> all outputs 0 and state LOST.
REQ-037 First lock: FE with col=100, row=200 -> next cycle oPosX=100, oPosY=200, oPosValid=1, no oMoveValid.
REQ-038 EMA: with avg_x=100, FE with col=200 (SHIFT=2) -> oPosX=125.
REQ-039 Move: from a lock at (100,200), three FEs with col=300 -> oPosX sequence 150, 187, 215; oMoveValid pulses on the third FE with oMove=4; anchor_x=215.
REQ-040 Lost and disable: FE with col=1023 -> oPosValid=0 and oPosX held; the next FE with col=50 loads oPosX=50; an FE with iEnable=0 leaves oFrameCount unchanged.
REQ-041 Interrupted confirm: two right-moving frames then one below-threshold frame -> no pulse and return to TRACK; reset during CONFIRM -> no pulse.
